// File: rtl/i_o_uart_rx_fifo.sv
// Parametrised UART receiver (majority-vote sampling, parity/framing checks) with a FWFT output FIFO.
// Latency: rx_valid rises 1 cycle after the mid-stop sample when the FIFO is empty.
// Backpressure: rx_ready stalls the FIFO head; a frame completing into a full FIFO is dropped with an rx_overrun pulse.
module i_o_uart_rx_fifo #(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int MSB_FIRST  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
   localparam int TW         = $clog2(BIT_PERIOD + 1);
   localparam int BCW        = $clog2(DATA_BITS + 1);
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int EW         = DATA_BITS + 2;

   localparam logic [TW-1:0] T_FULL = TW'(BIT_PERIOD);
   localparam logic [TW-1:0] T_HALF = TW'(BIT_PERIOD / 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DRAIN
   } state_t;

   state_t                state, state_nx;
   logic                  sync1, s0;
   logic [1:0]            hist;
   logic                  maj;
   logic [TW-1:0]         tmr;
   logic                  fire;
   logic [BCW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0]  shreg;
   logic                  perr, ferr;
   logic                  push;
   logic [EW-1:0]         push_dat;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW:0]           wptr, rptr;
   logic                  empty, full, pop, wr_en;
   logic [EW-1:0]         head;

   // Two-flop synchroniser plus two older samples for the majority vote; idle-high on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         s0    <= 1'b1;
         hist  <= 2'b11;
      end else begin
         sync1 <= rxd;
         s0    <= sync1;
         hist  <= {hist[0], s0};
      end
   end

   // Vote over the current synchronised sample and the two before it.
   assign maj  = (s0 & hist[0]) | (s0 & hist[1]) | (hist[0] & hist[1]);

   // Timer counts down after a load; it fires on the cycle it steps down to zero.
   assign fire = (tmr == TW'(1));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!s0) state_nx = S_START;
         S_START:  if (fire) state_nx = maj ? S_IDLE : S_DATA;
         S_DATA:   if (fire && bit_cnt == BCW'(DATA_BITS - 1))
                      state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (fire) state_nx = S_STOP;
         S_STOP:   if (fire && bit_cnt == BCW'(STOP_BITS - 1))
                      state_nx = maj ? S_IDLE : S_DRAIN;
         S_DRAIN:  if (s0) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: busy outside IDLE, FIFO push on the final mid-stop sample.
   always_comb begin
      rx_busy  = (state != S_IDLE);
      push     = (state == S_STOP) && fire && (bit_cnt == BCW'(STOP_BITS - 1));
      push_dat = {shreg, perr, ferr | ~maj};
   end

   // Receive datapath: bit timer, bit/stop counter, shift register, error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         if (tmr != '0) tmr <= tmr - 1'b1;
         case (state)
            S_IDLE: begin
               perr <= 1'b0;
               ferr <= 1'b0;
               if (!s0) tmr <= T_HALF;
            end
            S_START: if (fire) begin
               tmr     <= T_FULL;
               bit_cnt <= '0;
            end
            S_DATA: if (fire) begin
               tmr <= T_FULL;
               if (MSB_FIRST != 0) shreg <= {shreg[DATA_BITS-2:0], maj};
               else                shreg <= {maj, shreg[DATA_BITS-1:1]};
               if (bit_cnt == BCW'(DATA_BITS - 1)) bit_cnt <= '0;
               else                                bit_cnt <= bit_cnt + 1'b1;
            end
            S_PARITY: if (fire) begin
               tmr  <= T_FULL;
               perr <= (((^shreg) ^ maj) != (PARITY == 1));
            end
            S_STOP: if (fire) begin
               tmr     <= T_FULL;
               bit_cnt <= bit_cnt + 1'b1;
               if (!maj) ferr <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // FIFO control: extra wrap bit distinguishes full from empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !empty && rx_ready;
   assign wr_en = push && (!full || pop);

   // FIFO pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
      end
   end

   // FIFO storage; contents need no reset because outputs are gated by empty.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem[wptr[AW-1:0]] <= push_dat;
   end

   // Head entry presentation, forced to zero while empty.
   always_comb begin
      head          = mem[rptr[AW-1:0]];
      rx_valid      = !empty;
      rx_data       = empty ? '0 : head[EW-1:2];
      rx_parity_err = !empty && head[1];
      rx_frame_err  = !empty && head[0];
      rx_overrun    = push && full && !pop;
   end

endmodule

// File: tb/tb_i_o_uart_rx_fifo.sv
// Bench for i_o_uart_rx_fifo: an 8N1 instance (a) and an 8E1 instance (b) at 16 clocks per bit.
// Expected frames come from a queue model filled by the serial driver; a monitor checks every pop.
// rx_ready is driven by a mode variable: held low, held high, or randomised per cycle.
module tb_i_o_uart_rx_fifo;

   localparam int BP    = 16;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_ready;
   logic       rxd_a, rxd_b;
   logic       rx_valid_a, rx_valid_b;
   logic [7:0] rx_data_a, rx_data_b;
   logic       perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pops_a   = 0;
   int   pops_b   = 0;
   int   ovr_cnt_a = 0;
   int   ovr_cnt_b = 0;
   int   exp_ovr_a = 0;
   int   ready_mode = 0;
   ent_t exp_a[$];
   ent_t exp_b[$];
   ent_t ea, eb;

   always #5 clk = ~clk;

   i_o_uart_rx_fifo #(.CLOCK_FREQ(160), .BAUD_RATE(10)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_a),
      .rx_valid(rx_valid_a), .rx_ready(rx_ready), .rx_data(rx_data_a),
      .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .rx_busy(busy_a));

   i_o_uart_rx_fifo #(.CLOCK_FREQ(160), .BAUD_RATE(10), .PARITY(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_b),
      .rx_valid(rx_valid_b), .rx_ready(rx_ready), .rx_data(rx_data_b),
      .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .rx_busy(busy_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Consumer handshake: low, high or random, updated just after each rising edge.
   initial begin
      rx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Pop monitors: every handshake must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && rx_valid_a && rx_ready) begin
         pops_a++;
         if (exp_a.size() == 0) chk("a_unexpected_pop", 1, 0);
         else begin
            ea = exp_a.pop_front();
            chk("a_data", rx_data_a, ea.d);
            chk("a_perr", perr_a, ea.pe);
            chk("a_ferr", ferr_a, ea.fe);
         end
      end
      if (rst_n && rx_valid_b && rx_ready) begin
         pops_b++;
         if (exp_b.size() == 0) chk("b_unexpected_pop", 1, 0);
         else begin
            eb = exp_b.pop_front();
            chk("b_data", rx_data_b, eb.d);
            chk("b_perr", perr_b, eb.pe);
            chk("b_ferr", ferr_b, eb.fe);
         end
      end
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
   end

   task automatic line(input bit tgt, input logic v, input int n);
      if (tgt) rxd_b = v;
      else     rxd_a = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One serial frame, LSB first; instance b always carries an even-parity bit.
   task automatic send(input bit tgt, input logic [7:0] d, input bit bad_par,
                       input int stop_low, input bit glitch);
      ent_t e;
      int   off;
      line(tgt, 1'b0, BP);
      for (int i = 0; i < 8; i++) begin
         if (glitch && $urandom_range(0, 1) == 1) begin
            off = $urandom_range(1, 14);
            line(tgt, d[i], off);
            line(tgt, ~d[i], 1);
            line(tgt, d[i], BP - 1 - off);
         end else begin
            line(tgt, d[i], BP);
         end
      end
      if (tgt) line(tgt, (^d) ^ bad_par, BP);
      e.d  = d;
      e.pe = tgt ? bad_par : 1'b0;
      e.fe = (stop_low > 0);
      if (tgt) begin
         if (exp_b.size() < DEPTH) exp_b.push_back(e);
      end else begin
         if (exp_a.size() < DEPTH) exp_a.push_back(e);
         else                      exp_ovr_a++;
      end
      if (stop_low > 0) begin
         line(tgt, 1'b0, BP * stop_low);
         line(tgt, 1'b1, 2 * BP);
      end else begin
         line(tgt, 1'b1, BP);
      end
   endtask

   initial begin
      int pa;
      rst_n = 1'b0;
      rxd_a = 1'b1;
      rxd_b = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid_a", rx_valid_a, 0);
      chk("rst_data_a", rx_data_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_ovr_a", ovr_a, 0);
      chk("rst_valid_b", rx_valid_b, 0);
      chk("rst_flags_b", {perr_b, ferr_b}, 0);
      wait_cyc(2);
      ready_mode = 1;

      // Plain 8N1 frame with busy observed mid-frame and after the stop bit.
      fork
         send(0, 8'hA5, 0, 0, 0);
         begin
            wait_cyc(80);
            @(negedge clk);
            chk("busy_mid_frame", busy_a, 1);
         end
      join
      wait_cyc(8);
      chk("busy_after_frame", busy_a, 0);
      chk("pops_a5", pops_a, 1);

      // Even parity: deliberately wrong bit, then the correct one.
      send(1, 8'h3C, 1, 0, 0);
      send(1, 8'h3C, 0, 0, 0);
      wait_cyc(10);
      chk("pops_parity", pops_b, 2);

      // False start of 6 low cycles.
      pa = pops_a;
      line(0, 1'b0, 6);
      line(0, 1'b1, 3 * BP);
      chk("false_start_busy", busy_a, 0);
      chk("false_start_valid", rx_valid_a, 0);
      chk("false_start_pops", pops_a, pa);

      // Single-cycle glitches inside data bits.
      send(0, 8'hC3, 0, 0, 1);
      send(0, 8'h5A, 0, 0, 1);

      // Stop held low for three bit periods, then a clean frame.
      send(0, 8'h55, 0, 3, 0);
      send(0, 8'h12, 0, 0, 0);
      wait_cyc(10);
      chk("pops_after_break", pops_a, pa + 4);

      // Overrun: five frames into a stalled depth-4 FIFO.
      ready_mode = 0;
      wait_cyc(2);
      for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 0);
      wait_cyc(4);
      chk("overrun_pulses", ovr_cnt_a, 1);
      chk("full_valid", rx_valid_a, 1);
      chk("full_head", rx_data_a, 8'h01);
      pa = pops_a;
      ready_mode = 1;
      wait_cyc(12);
      chk("drain_pops", pops_a, pa + 4);
      chk("drain_empty", rx_valid_a, 0);

      // Reset in the middle of a frame with two entries queued.
      ready_mode = 0;
      wait_cyc(2);
      send(0, 8'h21, 0, 0, 0);
      send(0, 8'h22, 0, 0, 0);
      wait_cyc(4);
      chk("queued_valid", rx_valid_a, 1);
      line(0, 1'b0, BP);
      line(0, 1'b1, 3 * BP);
      chk("busy_before_reset", busy_a, 1);
      rst_n = 1'b0;
      wait_cyc(1);
      rst_n = 1'b1;
      rxd_a = 1'b1;
      exp_a.delete();
      @(negedge clk);
      chk("mid_rst_valid", rx_valid_a, 0);
      chk("mid_rst_data", rx_data_a, 0);
      chk("mid_rst_flags", {perr_a, ferr_a}, 0);
      chk("mid_rst_ovr", ovr_a, 0);
      chk("mid_rst_busy", busy_a, 0);
      wait_cyc(3 * BP);
      chk("post_rst_quiet", rx_valid_a, 0);
      pa = pops_a;
      ready_mode = 1;
      wait_cyc(2);
      send(0, 8'h99, 0, 0, 0);
      wait_cyc(10);
      chk("post_rst_single", pops_a, pa + 1);

      // Random frames, random glitches and random consumer stalls.
      ready_mode = 2;
      for (int i = 0; i < 24; i++) begin
         send(i % 2, 8'($urandom_range(0, 255)), (i % 2 == 1) && ($urandom_range(0, 3) == 0),
              0, 1'($urandom_range(0, 1)));
         wait_cyc($urandom_range(0, 20));
      end
      ready_mode = 1;
      wait_cyc(20);
      chk("final_queue_a", exp_a.size(), 0);
      chk("final_queue_b", exp_b.size(), 0);
      chk("final_ovr_a", ovr_cnt_a, exp_ovr_a);
      chk("final_ovr_b", ovr_cnt_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
